sdram_arbiter: RTL

//  Shares the single-port SDRAM controller between video, CPU and DMA requesters.
//  At each memory slot it picks one winner and drives the controller's cyc/REQ/RNW/A/DI/bsel.
//  It tracks which requester owns the outstanding read and returns that data to it.
//  It forces refresh slots when the memory has been busy for too long.

---
 rtl/sdram_arbiter_if.sv | 36 +++
 rtl/sdram_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the three memory requesters, the slot arbiter and the
// single-port SDRAM controller.
interface sdram_arbiter_if;
  logic        v_req,    c_req,    d_req;
  logic        v_rnw,    c_rnw,    d_rnw;
  logic [23:0] v_addr,   c_addr,   d_addr;
  logic [15:0] v_wdata,  c_wdata,  d_wdata;
  logic [1:0]  v_bsel,   c_bsel,   d_bsel;
  logic        v_ack,    c_ack,    d_ack;
  logic        v_rvalid, c_rvalid, d_rvalid;
  logic [15:0] rdata;
  logic        mem_cyc;
  logic        mem_req;
  logic        mem_rnw;
  logic [23:0] mem_a;
  logic [15:0] mem_di;
  logic [1:0]  mem_bsel;
  logic        mem_curr_cpu;
  logic [15:0] mem_do;

  modport slave (
    input  v_req, c_req, d_req, v_rnw, c_rnw, d_rnw,
    input  v_addr, c_addr, d_addr, v_wdata, c_wdata, d_wdata,
    input  v_bsel, c_bsel, d_bsel, mem_do,
    output v_ack, c_ack, d_ack, v_rvalid, c_rvalid, d_rvalid, rdata,
    output mem_cyc, mem_req, mem_rnw, mem_a, mem_di, mem_bsel, mem_curr_cpu
  );

  modport master (
    output v_req, c_req, d_req, v_rnw, c_rnw, d_rnw,
    output v_addr, c_addr, d_addr, v_wdata, c_wdata, d_wdata,
    output v_bsel, c_bsel, d_bsel, mem_do,
    input  v_ack, c_ack, d_ack, v_rvalid, c_rvalid, d_rvalid, rdata,
    input  mem_cyc, mem_req, mem_rnw, mem_a, mem_di, mem_bsel, mem_curr_cpu
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Per-slot arbiter sharing one SDRAM controller between video, CPU and DMA,
// with DMA anti-starvation, forced refresh slots and read-data return routing.
//
// state    | meaning
// ST_IDLE  | waiting for slot_pre; arbitration happens on the slot_pre clock
// ST_ISSUE | mem_cyc high for one clk; previous slot's read data is returned after it
module sdram_arbiter #(
  parameter int DMA_STARVE = 4,
  parameter int REF_MAX    = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           slot_pre,
  sdram_arbiter_if.slave bus
);

  localparam int SW = $clog2(DMA_STARVE + 1);
  localparam int RW = $clog2(REF_MAX + 1);

  localparam logic [1:0] ID_V = 2'd0;
  localparam logic [1:0] ID_C = 2'd1;
  localparam logic [1:0] ID_D = 2'd2;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t      state_q, state_d;
  logic        decide, retire;
  logic        grant_v, grant_c, grant_d, any_grant;
  logic [1:0]  sel_id;
  logic        sel_rnw;
  logic [23:0] sel_addr;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_bsel;
  logic [SW-1:0] starve_q, starve_d;
  logic [RW-1:0] ref_q, ref_d;
  logic        owner_valid;
  logic [1:0]  owner_id;
  logic        ret_valid;
  logic [1:0]  ret_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // slot_pre arriving during ST_ISSUE cannot happen with legal spacing and is dropped
  always_comb begin
    state_d = state_q;
    decide  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slot_pre) begin
          state_d = ST_ISSUE;
          decide  = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_IDLE;
        retire  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_v = 1'b0;
    grant_c = 1'b0;
    grant_d = 1'b0;
    if (ref_q != RW'(REF_MAX)) begin
      if (bus.v_req)
        grant_v = 1'b1;
      else if (bus.c_req && !(bus.d_req && starve_q == SW'(DMA_STARVE)))
        grant_c = 1'b1;
      else if (bus.d_req)
        grant_d = 1'b1;
    end
    any_grant = grant_v | grant_c | grant_d;
  end

  always_comb begin
    sel_id    = ID_D;
    sel_rnw   = bus.d_rnw;
    sel_addr  = bus.d_addr;
    sel_wdata = bus.d_wdata;
    sel_bsel  = bus.d_bsel;
    if (grant_v) begin
      sel_id    = ID_V;
      sel_rnw   = bus.v_rnw;
      sel_addr  = bus.v_addr;
      sel_wdata = bus.v_wdata;
      sel_bsel  = bus.v_bsel;
    end else if (grant_c) begin
      sel_id    = ID_C;
      sel_rnw   = bus.c_rnw;
      sel_addr  = bus.c_addr;
      sel_wdata = bus.c_wdata;
      sel_bsel  = bus.c_bsel;
    end
  end

  // Starvation only advances when DMA actually loses to the CPU; losing to video holds it
  always_comb begin
    starve_d = starve_q;
    if (!bus.d_req || grant_d)
      starve_d = '0;
    else if (grant_c && starve_q != SW'(DMA_STARVE))
      starve_d = starve_q + SW'(1);

    ref_d = '0;
    if (any_grant)
      ref_d = (ref_q == RW'(REF_MAX)) ? ref_q : ref_q + RW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.v_ack        <= 1'b0;
      bus.c_ack        <= 1'b0;
      bus.d_ack        <= 1'b0;
      bus.v_rvalid     <= 1'b0;
      bus.c_rvalid     <= 1'b0;
      bus.d_rvalid     <= 1'b0;
      bus.rdata        <= '0;
      bus.mem_cyc      <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.mem_rnw      <= 1'b0;
      bus.mem_a        <= '0;
      bus.mem_di       <= '0;
      bus.mem_bsel     <= '0;
      bus.mem_curr_cpu <= 1'b0;
      starve_q         <= '0;
      ref_q            <= '0;
      owner_valid      <= 1'b0;
      owner_id         <= '0;
      ret_valid        <= 1'b0;
      ret_id           <= '0;
    end else begin
      bus.v_ack        <= decide & grant_v;
      bus.c_ack        <= decide & grant_c;
      bus.d_ack        <= decide & grant_d;
      bus.mem_cyc      <= decide;
      bus.mem_curr_cpu <= decide & owner_valid & (owner_id == ID_C);
      bus.v_rvalid     <= retire & ret_valid & (ret_id == ID_V);
      bus.c_rvalid     <= retire & ret_valid & (ret_id == ID_C);
      bus.d_rvalid     <= retire & ret_valid & (ret_id == ID_D);

      if (decide) begin
        bus.mem_req <= any_grant;
        if (any_grant) begin
          bus.mem_rnw  <= sel_rnw;
          bus.mem_a    <= sel_addr;
          bus.mem_di   <= sel_wdata;
          bus.mem_bsel <= sel_bsel;
        end
        // The controller returns the previous slot's read during this slot's mem_cyc
        ret_valid   <= owner_valid;
        ret_id      <= owner_id;
        owner_valid <= any_grant & sel_rnw;
        owner_id    <= sel_id;
        starve_q    <= starve_d;
        ref_q       <= ref_d;
      end

      if (retire) begin
        if (ret_valid) bus.rdata <= bus.mem_do;
        ret_valid <= 1'b0;
      end
    end
  end

endmodule
